// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed-latency load/store access
// One request in flight; access happens at accept, response is presented after LATENCY cycles.
module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  input  logic [5:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic [5:0]  resp_rd,
  output logic        resp_err
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) * 64'd8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  count;
  logic        accept;
  logic        misaligned, err;
  logic [AW-1:0] idx;
  logic [63:0] rd_word, shifted, load_ext, wshift;
  logic [7:0]  lane_mask, byte_en;
  logic [63:0] mem [DEPTH_WORDS];

  assign accept  = req_valid && req_ready;
  assign idx     = req_addr[3 +: AW];
  assign rd_word = mem[idx];
  assign shifted = rd_word >> {req_addr[2:0], 3'b000};
  assign wshift  = req_wdata << {req_addr[2:0], 3'b000};
  assign byte_en = lane_mask << req_addr[2:0];
  assign err     = misaligned || (req_addr >= LIMIT);

  always_comb begin
    misaligned = 1'b0;
    lane_mask  = 8'h01;
    load_ext   = '0;
    case (req_size)
      2'd0: begin
        lane_mask = 8'h01;
        load_ext  = req_unsigned ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        misaligned = req_addr[0];
        lane_mask  = 8'h03;
        load_ext   = req_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      2'd2: begin
        misaligned = |req_addr[1:0];
        lane_mask  = 8'h0F;
        load_ext   = req_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      default: begin
        misaligned = |req_addr[2:0];
        lane_mask  = 8'hFF;
        load_ext   = shifted;
      end
    endcase
  end

  // Array has no reset; faulting stores never touch it.
  always_ff @(posedge clk) begin
    if (accept && !req_load && !err) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (accept) state_next = (LATENCY > 1) ? WAIT : RESP;
      end
      WAIT: if (count == 4'd1) state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      resp_data <= '0;
      resp_rd   <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        resp_rd   <= req_rd;
        resp_err  <= err;
        resp_data <= (req_load && !err) ? load_ext : 64'd0;
        count     <= 4'(LATENCY - 1);
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
    end
  end

endmodule
